seq_pattern_detector: RTL

SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

---
 rtl/pattern_pkg.sv | 18 +
 rtl/pattern_shift_reg.sv | 27 ++
 rtl/seq_pattern_detector.sv | 114 +++++++++++
 3 files changed

// File: rtl/pattern_pkg.sv
// pattern_pkg: state encoding and parameter limits shared by the serial pattern detector.
`default_nettype none

package pattern_pkg;

   typedef enum logic {
      FILL  = 1'b0,
      ARMED = 1'b1
   } state_t;

   localparam int PAT_W_MIN = 2;
   localparam int PAT_W_MAX = 32;
   localparam int CNT_W_MIN = 1;
   localparam int CNT_W_MAX = 32;

endpackage

`default_nettype wire

// File: rtl/pattern_shift_reg.sv
// pattern_shift_reg: PAT_W-bit history shifter, newest bit enters at the LSB.
`default_nettype none

module pattern_shift_reg #(
   parameter int PAT_W = 4
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clr,
   input  logic             en,
   input  logic             din,
   output logic [PAT_W-1:0] q
);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= {q[PAT_W-2:0], din};
      end
   end

endmodule

`default_nettype wire

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: serial pattern matcher with overlap mode, registered match pulse
// and saturating match counter.
`default_nettype none

module seq_pattern_detector
   import pattern_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             x,
   input  logic             x_valid,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic             cfg_overlap,
   input  logic             clear,
   output logic             y,
   output logic [CNT_W-1:0] match_cnt,
   output logic             armed
);

   localparam int              FILL_W    = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   state_t             state, next_state;
   logic [FILL_W-1:0]  fill, next_fill, fill_inc;
   logic [CNT_W-1:0]   next_cnt;
   logic               next_y;
   logic [PAT_W-1:0]   pattern;
   logic               overlap;
   logic [PAT_W-1:0]   hist;
   logic [PAT_W-1:0]   shifted;
   logic               shift_en;
   logic               match;

   pattern_shift_reg #(
      .PAT_W (PAT_W)
   ) u_hist (
      .clk   (clk),
      .n_rst (n_rst),
      .clr   (clear),
      .en    (shift_en),
      .din   (x),
      .q     (hist)
   );

   // Match is judged on the post-shift view so the completing bit counts this cycle.
   assign shifted  = {hist[PAT_W-2:0], x};
   assign fill_inc = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
   assign match    = x_valid && (fill_inc == FILL_FULL) && (shifted == pattern);

   always_comb begin
      next_state = state;
      next_fill  = fill;
      next_cnt   = match_cnt;
      next_y     = 1'b0;
      shift_en   = 1'b0;
      if (clear) begin
         next_state = FILL;
         next_fill  = '0;
         next_cnt   = '0;
      end else if (cfg_load) begin
         next_state = FILL;
         next_fill  = '0;
      end else if (x_valid) begin
         shift_en = 1'b1;
         if (match) begin
            next_y = 1'b1;
            if (match_cnt != CNT_MAX) begin
               next_cnt = match_cnt + CNT_W'(1);
            end
            if (overlap) begin
               next_state = ARMED;
               next_fill  = FILL_FULL;
            end else begin
               next_state = FILL;
               next_fill  = '0;
            end
         end else begin
            next_fill  = fill_inc;
            next_state = (fill_inc == FILL_FULL) ? ARMED : FILL;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= FILL;
         fill      <= '0;
         match_cnt <= '0;
         y         <= 1'b0;
         pattern   <= '0;
         overlap   <= 1'b1;
      end else begin
         state     <= next_state;
         fill      <= next_fill;
         match_cnt <= next_cnt;
         y         <= next_y;
         // Clear outranks a simultaneous load and leaves the configuration alone.
         if (cfg_load && !clear) begin
            pattern <= cfg_pattern;
            overlap <= cfg_overlap;
         end
      end
   end

   assign armed = (state == ARMED);

endmodule

`default_nettype wire
